// File: rtl/header_assembler_pkg.sv
// Shared miner constants: header geometry, byte counter width and the assembler FSM encoding.
package header_assembler_pkg;

  localparam int HDR_BYTES_DEFAULT = 80;
  localparam int BYTE_W            = 8;
  localparam int HDR_W             = HDR_BYTES_DEFAULT * BYTE_W;
  localparam int CNT_W             = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_FULL    = 2'd2
  } asm_state_e;

endpackage

// File: rtl/header_assembler_if.sv
// UART-byte input side and header output side of the header assembler.
interface header_assembler_if
  import header_assembler_pkg::*;
#(
  parameter int HEADER_W = HDR_W
) ();

  logic [BYTE_W-1:0]   rx_data;
  logic                rx_ready;
  logic                header_ack;
  logic [HEADER_W-1:0] header_data;
  logic                header_valid;
  logic [CNT_W-1:0]    byte_count;
  logic                frame_error;
  logic                overrun;

  modport master (
    output rx_data, rx_ready, header_ack,
    input  header_data, header_valid, byte_count, frame_error, overrun
  );

  modport slave (
    input  rx_data, rx_ready, header_ack,
    output header_data, header_valid, byte_count, frame_error, overrun
  );

endinterface

// File: rtl/header_assembler_edge_detector.sv
// Single-pulse edge detector (EDGE=0 rising, EDGE=1 falling) that stays disarmed out of
// reset until the input has sat at its inactive level for a cycle.
module header_assembler_edge_detector #(
  parameter bit EDGE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic pulse
);

  logic prev_q;
  logic prev_d;
  logic armed_q;
  logic armed_d;
  logic inactive;

  always_comb begin
    inactive = EDGE ? sig_in : ~sig_in;
    prev_d   = sig_in;
    armed_d  = armed_q | inactive;
    pulse    = armed_q & (EDGE ? (~sig_in & prev_q) : (sig_in & ~prev_q));
  end

  // A level already active when reset releases must not look like a fresh edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      armed_q <= inactive;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/header_assembler.sv
// Assembles HEADER_BYTES UART bytes into one block header, first byte in the top bits,
// with inter-byte timeout and overrun reporting while a finished header is unconsumed.
module header_assembler
  import header_assembler_pkg::*;
#(
  parameter int HEADER_BYTES   = HDR_BYTES_DEFAULT,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic               clock,
  input  logic               reset,
  header_assembler_if.slave  bus
);

  localparam int                HW       = HEADER_BYTES * BYTE_W;
  localparam int                GAP_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(HEADER_BYTES - 1);

  asm_state_e       state_q, state_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [HW-1:0]    asm_q, asm_d;
  logic [HW-1:0]    header_data_q, header_data_d;
  logic             frame_error_q, frame_error_d;
  logic             overrun_q, overrun_d;

  logic             strobe;
  logic             accept;
  logic [CNT_W-1:0] cnt_base;
  logic [GAP_W-1:0] gap_inc;

  header_assembler_edge_detector #(
    .EDGE (1'b0)
  ) u_edge (
    .clock  (clock),
    .reset  (reset),
    .sig_in (bus.rx_ready),
    .pulse  (strobe)
  );

  always_comb begin
    state_d       = state_q;
    byte_count_d  = byte_count_q;
    gap_d         = '0;
    asm_d         = asm_q;
    header_data_d = header_data_q;
    frame_error_d = 1'b0;
    overrun_d     = 1'b0;
    accept        = 1'b0;
    cnt_base      = (state_q == ST_RECEIVE) ? byte_count_q : '0;
    gap_inc       = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;

    unique case (state_q)
      ST_IDLE: accept = strobe;
      ST_RECEIVE: begin
        // A strobe landing on the timeout cycle still wins over the abort.
        if (strobe) begin
          accept = 1'b1;
        end else if (gap_q == GAP_MAX) begin
          frame_error_d = 1'b1;
          byte_count_d  = '0;
          state_d       = ST_IDLE;
        end else begin
          gap_d = gap_inc;
        end
      end
      ST_FULL: begin
        if (strobe && bus.header_ack) begin
          accept = 1'b1;
        end else if (strobe) begin
          overrun_d = 1'b1;
        end else if (bus.header_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      asm_d = {asm_q[HW-BYTE_W-1:0], bus.rx_data};
      if (cnt_base == LAST_IDX) begin
        header_data_d = asm_d;
        byte_count_d  = '0;
        state_d       = ST_FULL;
      end else begin
        byte_count_d  = cnt_base + 1'b1;
        state_d       = ST_RECEIVE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      byte_count_q  <= '0;
      gap_q         <= '0;
      header_data_q <= '0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_count_q  <= byte_count_d;
      gap_q         <= gap_d;
      header_data_q <= header_data_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  // Stale assembly bits are fully shifted out before they can reach header_data.
  always_ff @(posedge clock) begin
    asm_q <= asm_d;
  end

  assign bus.header_data  = header_data_q;
  assign bus.header_valid = (state_q == ST_FULL);
  assign bus.byte_count   = byte_count_q;
  assign bus.frame_error  = frame_error_q;
  assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_header_assembler.sv
// Randomized bench for header_assembler: a byte-queue reference model feeds expectation
// queues that a separate monitor pops whenever the DUT raises a header, error or overrun.
module tb_header_assembler;
  import header_assembler_pkg::*;

  localparam int HB = 80;
  localparam int TO = 100;
  localparam int HW = HB * 8;

  logic clk;
  logic reset;

  header_assembler_if #(.HEADER_W(HW)) bus ();

  header_assembler #(
    .HEADER_BYTES   (HB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [HW-1:0] exp_hdr_q[$];
  int            exp_err_q[$];
  int            exp_ovr_q[$];

  logic [7:0]    m_bytes[$];
  logic          m_full = 1'b0;
  logic [HW-1:0] m_last = '0;
  int            since  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_hdr(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [HW-1:0] build_header();
    logic [HW-1:0] h;
    h = '0;
    for (int i = 0; i < HB; i++) h[HW-1-8*i -: 8] = m_bytes[i];
    return h;
  endfunction

  // One byte: rx_ready high for 'hold' cycles then low for 'gap' cycles (gap >= 1).
  task automatic send(input logic [7:0] b, input int hold, input int gap, input bit ack);
    bit exp_ovr;
    exp_ovr = 1'b0;
    if (m_full && !ack) begin
      exp_ovr = 1'b1;
      exp_ovr_q.push_back(1);
    end else begin
      m_full = 1'b0;
      m_bytes.push_back(b);
      if (m_bytes.size() == HB) begin
        m_last = build_header();
        exp_hdr_q.push_back(m_last);
        m_bytes.delete();
        m_full = 1'b1;
      end
    end
    bus.rx_data    = b;
    bus.rx_ready   = 1'b1;
    bus.header_ack = ack;
    @(negedge clk);
    bus.header_ack = 1'b0;
    chk("byte_count", 64'(bus.byte_count), 64'(m_bytes.size()));
    chk("header_valid", 64'(bus.header_valid), 64'(m_full));
    chk("overrun", 64'(bus.overrun), 64'(exp_ovr));
    repeat (hold - 1) @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
    since = hold - 1 + gap;
  endtask

  task automatic idle(input int n);
    bit abort;
    abort = (m_bytes.size() > 0) && (since + n >= TO);
    if (abort) begin
      exp_err_q.push_back(1);
      m_bytes.delete();
    end
    since += n;
    repeat (n) @(negedge clk);
    if (abort) begin
      chk("timeout_byte_count", 64'(bus.byte_count), 64'd0);
      chk_hdr("timeout_header_kept", bus.header_data, m_last);
    end
  endtask

  task automatic ack_only();
    m_full = 1'b0;
    bus.header_ack = 1'b1;
    @(negedge clk);
    bus.header_ack = 1'b0;
    since += 1;
    chk("ack_header_valid", 64'(bus.header_valid), 64'd0);
    chk("ack_byte_count", 64'(bus.byte_count), 64'(m_bytes.size()));
  endtask

  // Monitor: pops the expectation queues whenever the DUT presents an event.
  initial begin
    logic hv_prev, fe_prev, ov_prev;
    hv_prev = 1'b0;
    fe_prev = 1'b0;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bus.header_valid && !hv_prev) begin
          if (exp_hdr_q.size() == 0) chk("unexpected_header", 64'd1, 64'd0);
          else chk_hdr("header_data", bus.header_data, exp_hdr_q.pop_front());
        end
        if (bus.frame_error) begin
          if (fe_prev) chk("frame_error_width", 64'd2, 64'd1);
          else if (exp_err_q.size() == 0) chk("unexpected_frame_error", 64'd1, 64'd0);
          else chk("frame_error_event", 64'(exp_err_q.pop_front()), 64'd1);
        end
        if (bus.overrun) begin
          if (ov_prev) chk("overrun_width", 64'd2, 64'd1);
          else if (exp_ovr_q.size() == 0) chk("unexpected_overrun", 64'd1, 64'd0);
          else chk("overrun_event", 64'(exp_ovr_q.pop_front()), 64'd1);
        end
      end
      hv_prev = bus.header_valid;
      fe_prev = bus.frame_error;
      ov_prev = bus.overrun;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    bus.rx_data    = '0;
    bus.rx_ready   = 1'b0;
    bus.header_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_byte_count", 64'(bus.byte_count), 64'd0);
    chk("rst_header_valid", 64'(bus.header_valid), 64'd0);
    chk("rst_frame_error", 64'(bus.frame_error), 64'd0);
    chk("rst_overrun", 64'(bus.overrun), 64'd0);
    chk_hdr("rst_header_data", bus.header_data, '0);
    reset = 1'b1;
    @(negedge clk);

    // Counting pattern 0x01..0x50, 10-cycle gaps.
    for (int i = 1; i <= HB; i++) send(8'(i), 1, 10, 1'b0);
    chk("first_byte_top", 64'(bus.header_data[HW-1 -: 8]), 64'h01);
    chk("last_byte_low", 64'(bus.header_data[7:0]), 64'h50);
    ack_only();

    // Long rx_ready level yields exactly one byte, then finish the frame randomly.
    send(8'hAB, 5, 2, 1'b0);
    for (int i = 1; i < HB; i++)
      send(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 6)), 1'b0);

    // Unacknowledged header: drop 0xFF, then byte accepted together with the ack.
    send(8'hFF, 1, 2, 1'b0);
    chk_hdr("overrun_header_kept", bus.header_data, m_last);
    send(8'h11, 1, 2, 1'b1);

    // Ten bytes then a long silence aborts the frame.
    for (int i = 0; i < 9; i++) send(8'($urandom), 1, 2, 1'b0);
    idle(TO);

    // Strobe on the very cycle the gap counter hits its limit is still accepted.
    send(8'h3C, 1, TO - 1, 1'b0);
    send(8'hC3, 1, 2, 1'b0);
    idle(TO + 5);

    // header_ack outside FULL has no effect.
    ack_only();
    send(8'h77, 1, 2, 1'b0);
    ack_only();

    // Reset after 40 bytes with rx_ready held high across the release.
    for (int i = 1; i < 40; i++) send(8'($urandom), 1, 2, 1'b0);
    reset        = 1'b0;
    bus.rx_data  = 8'h5A;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    m_bytes.delete();
    m_full = 1'b0;
    m_last = '0;
    chk("rst2_byte_count", 64'(bus.byte_count), 64'd0);
    chk("rst2_header_valid", 64'(bus.header_valid), 64'd0);
    chk("rst2_frame_error", 64'(bus.frame_error), 64'd0);
    chk("rst2_overrun", 64'(bus.overrun), 64'd0);
    chk_hdr("rst2_header_data", bus.header_data, '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_strobe_after_reset", 64'(bus.byte_count), 64'd0);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < HB; i++)
      send(8'($urandom), int'($urandom_range(1, 2)), int'($urandom_range(1, 4)), 1'b0);
    ack_only();

    // Random frames; a byte arriving while a header is pending is either dropped or
    // accepted together with a same-cycle ack.
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < HB; i++)
        send(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 5)),
             m_full && ($urandom_range(0, 1) == 1));
    ack_only();
    idle(5);

    chk("pending_headers", 64'(exp_hdr_q.size()), 64'd0);
    chk("pending_frame_errors", 64'(exp_err_q.size()), 64'd0);
    chk("pending_overruns", 64'(exp_ovr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
